// File: rtl/nn_pkg.sv
// -----------------------------------------------------------------------------
// nn_pkg
// Shared definitions for the neural-network datapath blocks.
//   FP32_W         : IEEE-754 single-precision word width
//   FP32_SIGN_BIT  : bit index of the sign in an FP32 word
//   seq_state_e    : layer sequencer FSM states
//   fp32_is_zero() : true for +0.0 and -0.0 (all bits except the sign clear)
// -----------------------------------------------------------------------------
package nn_pkg;

    localparam int FP32_W        = 32;
    localparam int FP32_SIGN_BIT = 31;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    // Both signed zeroes are treated as zero, so the sign bit is masked off
    // before the compare.
    function automatic logic fp32_is_zero(input logic [FP32_W-1:0] value);
        logic [FP32_W-1:0] magnitude;
        magnitude                = value;
        magnitude[FP32_SIGN_BIT] = 1'b0;
        return (magnitude == '0);
    endfunction

endpackage : nn_pkg

// File: rtl/relu_layer_sequencer.sv
// -----------------------------------------------------------------------------
// relu_layer_sequencer
// Streams one layer of pre-activation sums from the accumulator RAM through
// the external `relu` unit and writes the results, in order, into the
// activation buffer of the next layer. Also counts results equal to zero.
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   start        in   single-cycle request to process one layer
//   sum_rd_addr  out  accumulator RAM read address (data returns 1 cycle later)
//   sum_rd_data  in   accumulator RAM read data
//   relu_in      out  registered operand to `relu`
//   relu_valid   out  registered operand valid
//   relu_out     in   `relu` result
//   relu_done    in   `relu` result valid, 1 cycle after relu_valid
//   act_wr_en    out  activation buffer write strobe (registered)
//   act_wr_addr  out  activation buffer write address
//   act_wr_data  out  activation value
//   busy         out  high from start acceptance through the layer_done cycle
//   layer_done   out  one-cycle pulse after the last result is written
//   zero_count   out  number of zero results in the current/last layer
//
// Pipeline (start sampled at edge 0, element k):
//   cycle k+1  sum_rd_addr = k, read-valid flop set on the following edge
//   cycle k+2  sum_rd_data valid
//   cycle k+3  relu_in / relu_valid
//   cycle k+4  relu_done / relu_out
//   cycle k+5  act_wr_en / act_wr_addr / act_wr_data
// -----------------------------------------------------------------------------
module relu_layer_sequencer
    import nn_pkg::*;
#(
    parameter int NUM_NEURONS = 64,
    parameter int DATA_W      = FP32_W,
    parameter int ADDR_W      = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,

    output logic [ADDR_W-1:0] sum_rd_addr,
    input  logic [DATA_W-1:0] sum_rd_data,

    output logic [DATA_W-1:0] relu_in,
    output logic              relu_valid,
    input  logic [DATA_W-1:0] relu_out,
    input  logic              relu_done,

    output logic              act_wr_en,
    output logic [ADDR_W-1:0] act_wr_addr,
    output logic [DATA_W-1:0] act_wr_data,

    output logic              busy,
    output logic              layer_done,
    output logic [ADDR_W:0]   zero_count
);

    // Address of the final element and the write count that completes a layer.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_NEURONS - 1);
    localparam logic [ADDR_W:0]   LAYER_CNT = (ADDR_W + 1)'(NUM_NEURONS);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    seq_state_e        state_q,       state_d;
    logic [ADDR_W-1:0] rd_ptr_q,      rd_ptr_d;
    logic              rd_valid_q,    rd_valid_d;
    logic [DATA_W-1:0] relu_in_q,     relu_in_d;
    logic              relu_valid_q,  relu_valid_d;
    logic              act_wr_en_q,   act_wr_en_d;
    logic [ADDR_W-1:0] act_wr_addr_q, act_wr_addr_d;
    logic [DATA_W-1:0] act_wr_data_q, act_wr_data_d;
    logic [ADDR_W:0]   wr_cnt_q,      wr_cnt_d;
    logic [ADDR_W:0]   zero_count_q,  zero_count_d;

    // Results are only accepted while a layer is in flight; a stray relu_done
    // in IDLE or DONE must not write the buffer or touch the zero count.
    logic accept_result;

    assign accept_result = relu_done && ((state_q == ISSUE) || (state_q == DRAIN));

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default at the top of the block so no
        // path through the case statement can leave it unassigned (no latch).
        state_d       = state_q;
        rd_ptr_d      = rd_ptr_q;
        rd_valid_d    = 1'b0;
        relu_in_d     = relu_in_q;
        relu_valid_d  = rd_valid_q;
        act_wr_en_d   = 1'b0;
        act_wr_addr_d = act_wr_addr_q;
        act_wr_data_d = act_wr_data_q;
        wr_cnt_d      = wr_cnt_q;
        zero_count_d  = zero_count_q;

        // Operand register only loads on a valid read, so it holds its last
        // value while relu_valid is low.
        if (rd_valid_q) begin
            relu_in_d = sum_rd_data;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = ISSUE;
                    rd_ptr_d     = '0;
                    wr_cnt_d     = '0;
                    zero_count_d = '0;
                end
            end

            ISSUE: begin
                // One read per cycle; the read-valid flop tags the address
                // presented in this cycle.
                rd_valid_d = 1'b1;
                rd_ptr_d   = rd_ptr_q + ADDR_ONE;
                if (rd_ptr_q == LAST_ADDR) begin
                    state_d = DRAIN;
                end
            end

            DRAIN: begin
                // wr_cnt_q already reflects the final write edge here.
                if (wr_cnt_q == LAYER_CNT) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                // start is ignored in this cycle; IDLE accepts it next cycle.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Results arrive in issue order with no gaps, so the running write
        // count is the destination address.
        if (accept_result) begin
            act_wr_en_d   = 1'b1;
            act_wr_addr_d = wr_cnt_q[ADDR_W-1:0];
            act_wr_data_d = relu_out;
            wr_cnt_d      = wr_cnt_q + CNT_ONE;
            if (fp32_is_zero(relu_out)) begin
                zero_count_d = zero_count_q + CNT_ONE;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            rd_ptr_q      <= '0;
            rd_valid_q    <= 1'b0;
            relu_in_q     <= '0;
            relu_valid_q  <= 1'b0;
            act_wr_en_q   <= 1'b0;
            act_wr_addr_q <= '0;
            act_wr_data_q <= '0;
            wr_cnt_q      <= '0;
            zero_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            rd_ptr_q      <= rd_ptr_d;
            rd_valid_q    <= rd_valid_d;
            relu_in_q     <= relu_in_d;
            relu_valid_q  <= relu_valid_d;
            act_wr_en_q   <= act_wr_en_d;
            act_wr_addr_q <= act_wr_addr_d;
            act_wr_data_q <= act_wr_data_d;
            wr_cnt_q      <= wr_cnt_d;
            zero_count_q  <= zero_count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // The address is forced to 0 outside ISSUE so the RAM sees a quiet bus
    // between layers.
    assign sum_rd_addr = (state_q == ISSUE) ? rd_ptr_q : '0;
    assign relu_in     = relu_in_q;
    assign relu_valid  = relu_valid_q;
    assign act_wr_en   = act_wr_en_q;
    assign act_wr_addr = act_wr_addr_q;
    assign act_wr_data = act_wr_data_q;
    assign busy        = (state_q != IDLE);
    assign layer_done  = (state_q == DONE);
    assign zero_count  = zero_count_q;

endmodule : relu_layer_sequencer

// File: doc/relu_layer_sequencer.md
Name: relu_layer_sequencer

Overview:
Drives the `relu` unit from the producer side for one network layer. It reads NUM_NEURONS pre-activation sums (IEEE-754 single) from the accumulator RAM, issues them to `relu` on the `relu_in`/`relu_valid` interface, and collects `relu_out`/`relu_done`. Results go into the activation buffer feeding the next layer. It sits between the MAC/accumulator stage and the next layer's input buffer, and also reports how many neurons were clamped to zero.

Parameters:
- NUM_NEURONS, 64, number of sums processed per layer (≥2).
- DATA_W, 32, word width (IEEE-754 single).
- ADDR_W, 6, address width for both buffers; must satisfy 2**ADDR_W ≥ NUM_NEURONS.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to process one layer.
- sum_rd_addr  out  ADDR_W  accumulator RAM read address.
- sum_rd_data  in  DATA_W  accumulator RAM data, valid 1 cycle after the address.
- relu_in  out  DATA_W  operand to `relu` (registered).
- relu_valid  out  1  operand valid (registered).
- relu_out  in  DATA_W  `relu` result.
- relu_done  in  1  `relu` result valid; 1 cycle after `relu_valid`.
- act_wr_en  out  1  activation buffer write strobe (registered).
- act_wr_addr  out  ADDR_W  activation buffer write address.
- act_wr_data  out  DATA_W  activation value.
- busy  out  1  high from start acceptance through the layer_done cycle.
- layer_done  out  1  one-cycle pulse when all NUM_NEURONS results are written.
- zero_count  out  ADDR_W+1  number of results equal to zero in the current/last layer.

Behaviour:
- Reset values: all outputs are 0, the FSM is in IDLE, and all counters are 0. `zero_count` is cleared by reset and on start acceptance, and holds its value after layer_done.
- FSM states:
  - IDLE: if start is sampled high, go to ISSUE, clear rd_ptr, wr_cnt and zero_count, and set busy.
  - ISSUE: present `sum_rd_addr` = rd_ptr every cycle with rd_ptr incrementing by 1. In the cycle that presents NUM_NEURONS-1, go to DRAIN.
  - DRAIN: no new reads. When wr_cnt reaches NUM_NEURONS (after the final write edge), go to DONE.
  - DONE: layer_done = 1 for exactly one cycle, busy stays high in this cycle, then go to IDLE.
- Pipeline:
  - A read-valid flop is set for each issued address.
  - On the next edge, `relu_in` is loaded from `sum_rd_data` and `relu_valid` from the read-valid flop.
  - On each `relu_done` in ISSUE or DRAIN: the next edge registers act_wr_en=1, act_wr_addr=wr_cnt, act_wr_data=relu_out, and increments wr_cnt.
  - zero_count increments when relu_out[30:0]==0, so both +0 and -0 count.
- Timing, with start sampled at edge 0:
  - Address k is presented in cycle k+1.
  - relu_valid for element k is high in cycle k+3.
  - act_wr_en for element k is high in cycle k+5.
  - layer_done is high in cycle NUM_NEURONS+5.
  - For NUM_NEURONS=6, layer_done is in cycle 11.
- `relu_valid` is high for exactly NUM_NEURONS consecutive cycles per layer and 0 otherwise. `relu_in` holds its last value when valid is low.
- `relu_done` is ignored in IDLE and DONE. Results are written in order with no gaps.
- start while busy (including the DONE cycle) is ignored. start in the cycle after DONE is accepted.
- Reset mid-layer: on the next edge all state returns to IDLE and outputs to 0, with no layer_done pulse. Partial activation writes already made are not undone.
- No arithmetic is performed here; the ReLU clamp stays in `relu`.

Decomposition:
- Shared package `nn_pkg`:
  - FP32 width constant.
  - FP32 sign-bit index.
  - FSM state enum {IDLE, ISSUE, DRAIN, DONE}.
- Sub-module: none required. The FSM, counters and pipeline flops fit in one module. The bench instantiates the real `relu` and a behavioural 1-cycle-latency RAM model.

Test Plan:
- NUM_NEURONS=6, sums [C1233333, 3FCCCCCD, BF400000, 00000000, 42C04000, C2480000], start pulse at edge 0:
  - Activation buffer = [0, 3FCCCCCD, 0, 0, 42C04000, 0].
  - zero_count=4.
  - act_wr_en high cycles 5–10, layer_done only in cycle 11.
  - busy high cycles 1–11.
- Sum 80000000 (-0.0) among positives: the written value is 0 or 80000000 as `relu` produces it, and zero_count counts it.
- All-positive layer (each sum 3F800000): every write equals 3F800000 and zero_count=0.
- start re-pulsed in cycles 3 and 11: both are ignored, with exactly one layer_done. A start at cycle 12 begins a new layer and zero_count clears.
- reset asserted in cycle 6 of a layer: from cycle 7, busy=0, relu_valid=0, act_wr_en=0, zero_count=0, and no layer_done. A subsequent start completes normally.
- Spurious relu_done held high while IDLE: no act_wr_en and zero_count is unchanged.
